// File: rtl/mem_l1_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_l1_port_arb                                               |
// | Purpose  : Shares the single L2/bus memory port between the L1 I-cache   |
// |            and L1 D-cache miss paths. One tile transaction is in flight  |
// |            at a time. The UMEM OPM/OK handshake is used on every side.   |
// |            A response watchdog turns a hung transaction into FAULT.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock, reset(async, active-low)                                        |
// |   icMemOpm/icMemAddr      -> I-side request; icMemData/icMemOK response  |
// |   dcMemOpm/dcMemAddr/     -> D-side request + store data;                |
// |   dcMemDataOut               dcMemData/dcMemOK response                  |
// |   memOpm/memAddr/         <- registered downstream request               |
// |   memDataOut                                                             |
// |   memDataIn/memOK         -> downstream response                         |
// |   arbGrant                <- one-hot grant, bit0 = I, bit1 = D           |
// | Parameters                                                               |
// |   TIMEOUT_CYC : REQ cycles without a response before the watchdog fires  |
// | Build option                                                             |
// |   JX2_L1ARB_RR_EN : round-robin on simultaneous requests; when undefined |
// |                     the D side always wins a tie.                        |
// | Encodings                                                                |
// |   OPM READY = 5'h00; OK READY=0, OK=1, HOLD=2, FAULT=3                   |
// +--------------------------------------------------------------------------+
module mem_l1_port_arb #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [4:0]   icMemOpm,
  input  logic [31:0]  icMemAddr,
  output logic [127:0] icMemData,
  output logic [1:0]   icMemOK,
  input  logic [4:0]   dcMemOpm,
  input  logic [31:0]  dcMemAddr,
  input  logic [127:0] dcMemDataOut,
  output logic [127:0] dcMemData,
  output logic [1:0]   dcMemOK,
  output logic [4:0]   memOpm,
  output logic [31:0]  memAddr,
  output logic [127:0] memDataOut,
  input  logic [127:0] memDataIn,
  input  logic [1:0]   memOK,
  output logic [1:0]   arbGrant
);

  localparam logic [4:0] c_OPM_READY = 5'h00;
  localparam logic [1:0] c_OK_READY  = 2'b00;
  localparam logic [1:0] c_OK_OK     = 2'b01;
  localparam logic [1:0] c_OK_HOLD   = 2'b10;
  localparam logic [1:0] c_OK_FAULT  = 2'b11;
  localparam logic [1:0] c_GNT_NONE  = 2'b00;
  localparam logic [1:0] c_GNT_I     = 2'b01;
  localparam logic [1:0] c_GNT_D     = 2'b10;
  localparam logic [9:0] c_WD_LIMIT  = 10'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [1:0]     r_gnt;
  logic [1:0]     r_rrLast;
  logic [9:0]     r_wdCnt;
  logic           r_wdFault;
  logic [4:0]     r_memOpm;
  logic [31:0]    r_memAddr;
  logic [127:0]   r_memDataOut;

  logic           w_icReq;
  logic           w_dcReq;
  logic           w_pickDc;
  logic           w_srcDc;
  logic [4:0]     w_srcOpm;
  logic [31:0]    w_srcAddr;
  logic [127:0]   w_srcData;
  logic           w_dsResp;
  logic [9:0]     w_wdNext;
  logic [1:0]     w_grantedOK;

  assign w_icReq = (icMemOpm != c_OPM_READY);
  assign w_dcReq = (dcMemOpm != c_OPM_READY);

`ifdef JX2_L1ARB_RR_EN
  // On a tie, serve the side that did not own the last transaction.
  assign w_pickDc = w_dcReq && (!w_icReq || (r_rrLast != c_GNT_D));
`else
  // Fixed priority: D wins ties. The round-robin history is still tracked so
  // both builds carry identical state.
  assign w_pickDc = w_dcReq;
  logic w_unused_rrLast;
  assign w_unused_rrLast = ^r_rrLast;
`endif

  // In IDLE the source is the side about to be granted; afterwards it is the
  // side holding the grant.
  assign w_srcDc   = (r_state == S_IDLE) ? w_pickDc : r_gnt[1];
  assign w_srcOpm  = w_srcDc ? dcMemOpm  : icMemOpm;
  assign w_srcAddr = w_srcDc ? dcMemAddr : icMemAddr;
  assign w_srcData = w_srcDc ? dcMemDataOut : 128'd0;  // I side never stores

  assign w_dsResp  = (memOK == c_OK_OK) || (memOK == c_OK_FAULT);
  // Saturating: the counter never wraps past the limit.
  assign w_wdNext  = (r_wdCnt == c_WD_LIMIT) ? r_wdCnt : r_wdCnt + 10'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= c_GNT_NONE;
      r_rrLast     <= c_GNT_D;
      r_wdCnt      <= 10'd0;
      r_wdFault    <= 1'b0;
      r_memOpm     <= c_OPM_READY;
      r_memAddr    <= 32'd0;
      r_memDataOut <= 128'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_memOpm <= c_OPM_READY;
          if (w_icReq || w_dcReq) begin
            r_gnt        <= w_pickDc ? c_GNT_D : c_GNT_I;
            r_memOpm     <= w_srcOpm;
            r_memAddr    <= w_srcAddr;
            r_memDataOut <= w_srcData;
            r_state      <= S_REQ;
          end
        end

        S_REQ: begin
          // Track re-asserts from the owner. An owner that drops to READY has
          // abandoned the request; the downstream transaction is kept alive
          // with the last issued command so it can complete cleanly.
          if (w_srcOpm != c_OPM_READY) begin
            r_memOpm     <= w_srcOpm;
            r_memAddr    <= w_srcAddr;
            r_memDataOut <= w_srcData;
          end
          if (w_dsResp) begin
            r_state  <= S_DONE;
            r_memOpm <= c_OPM_READY;
          end else begin
            r_wdCnt <= w_wdNext;
            if (w_wdNext == c_WD_LIMIT) begin
              r_wdFault <= 1'b1;
              r_state   <= S_DONE;
              r_memOpm  <= c_OPM_READY;
            end
          end
        end

        S_DONE: begin
          r_memOpm <= c_OPM_READY;
          // After a watchdog fault the downstream may never answer, so the
          // release does not wait for memOK to return to READY.
          if ((w_srcOpm == c_OPM_READY) &&
              ((memOK == c_OK_READY) || r_wdFault)) begin
            r_state   <= S_IDLE;
            r_wdFault <= 1'b0;
            r_wdCnt   <= 10'd0;
            r_rrLast  <= r_gnt;
            r_gnt     <= c_GNT_NONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_grantedOK = ((r_state == S_DONE) && r_wdFault) ? c_OK_FAULT : memOK;

  // Zero-latency response routing. r_gnt is clear in IDLE, so both sides then
  // get the waiting-side answer and a fresh request sees HOLD.
  always_comb begin
    icMemOK = w_icReq ? c_OK_HOLD : c_OK_READY;
    dcMemOK = w_dcReq ? c_OK_HOLD : c_OK_READY;
    if (r_gnt[0]) begin
      icMemOK = w_grantedOK;
    end
    if (r_gnt[1]) begin
      dcMemOK = w_grantedOK;
    end
  end

  // Read data is broadcast; a side only consumes it alongside an OK, which
  // only the granted side can receive.
  assign icMemData  = memDataIn;
  assign dcMemData  = memDataIn;

  assign memOpm     = r_memOpm;
  assign memAddr    = r_memAddr;
  assign memDataOut = r_memDataOut;
  assign arbGrant   = r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_l1_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_l1_port_arb                                            |
// | Purpose  : Self-checking bench for mem_l1_port_arb: vector tables,       |
// |            directed corner-case sequences and a randomized run against   |
// |            a transaction-level reference model.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_l1_port_arb;

  localparam int         TO          = 8;
  localparam logic [4:0] OPM_READY   = 5'h00;
  localparam logic [4:0] OPM_RD      = 5'h12;
  localparam logic [4:0] OPM_WR      = 5'h13;
  localparam logic [4:0] OPM_FLUSHIS = 5'h19;
  localparam logic [1:0] OK_READY    = 2'b00;
  localparam logic [1:0] OK_OK       = 2'b01;
  localparam logic [1:0] OK_HOLD     = 2'b10;
  localparam logic [1:0] OK_FAULT    = 2'b11;
`ifdef JX2_L1ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [4:0]   icMemOpm, dcMemOpm, memOpm;
  logic [31:0]  icMemAddr, dcMemAddr, memAddr;
  logic [127:0] icMemData, dcMemData, dcMemDataOut, memDataOut, memDataIn;
  logic [1:0]   icMemOK, dcMemOK, memOK, arbGrant;

  mem_l1_port_arb #(.TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .icMemOpm(icMemOpm), .icMemAddr(icMemAddr), .icMemData(icMemData), .icMemOK(icMemOK),
    .dcMemOpm(dcMemOpm), .dcMemAddr(dcMemAddr), .dcMemDataOut(dcMemDataOut),
    .dcMemData(dcMemData), .dcMemOK(dcMemOK),
    .memOpm(memOpm), .memAddr(memAddr), .memDataOut(memDataOut),
    .memDataIn(memDataIn), .memOK(memOK), .arbGrant(arbGrant)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] ic; logic [4:0] dc; logic [1:0] mok;
    logic [1:0] eIc; logic [1:0] eDc;
  } rstVec_t;
  typedef struct {
    logic [4:0] ic; logic [4:0] dc;
    logic [1:0] eGnt; logic [31:0] eAddr; logic [4:0] eOpm;
  } arbVec_t;

  rstVec_t rstTab[4];
  arbVec_t arbTab[4];

  int nVec = 0;
  int nMis = 0;

  // Reference model: transaction view of the arbiter.
  int           mOwner;     // 0 none, 1 I, 2 D
  int           mLast;      // owner of the previous transaction
  int           mReqCnt;    // unanswered cycles of the current transaction
  bit           mFin;       // downstream part finished (answered or timed out)
  bit           mTo;        // finished by the watchdog
  logic [4:0]   eOpm;
  logic [31:0]  eAddr;
  logic [127:0] eData;
  logic [1:0]   eGnt, eIcOK, eDcOK;
  logic [4:0]   ownOpm;
  // Random-traffic helpers
  logic [1:0]   iSeen, dSeen, dsResp;
  bit           dsBusy, dsDone;
  int           dsLat, dsHold, winner;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    icMemOpm = OPM_READY; dcMemOpm = OPM_READY;
    icMemAddr = 32'd0; dcMemAddr = 32'd0; dcMemDataOut = 128'd0;
    memDataIn = 128'd0; memOK = OK_READY;
  endtask

  task automatic rstPulse();
    reset = 1'b0;
    idleInputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [4:0] rndOpm();
    case ($urandom_range(0, 2))
      0:       return OPM_RD;
      1:       return OPM_WR;
      default: return OPM_FLUSHIS;
    endcase
  endfunction

  initial begin
    logic [1:0]  firstGnt, secondGnt;
    logic [31:0] firstAddr, secondAddr;

    rstTab[0] = '{OPM_READY,   OPM_READY, OK_READY, OK_READY, OK_READY};
    rstTab[1] = '{OPM_RD,      OPM_READY, OK_OK,    OK_HOLD,  OK_READY};
    rstTab[2] = '{OPM_READY,   OPM_WR,    OK_HOLD,  OK_READY, OK_HOLD};
    rstTab[3] = '{OPM_FLUSHIS, OPM_RD,    OK_FAULT, OK_HOLD,  OK_HOLD};

    arbTab[0] = '{OPM_RD,      OPM_READY, 2'b01, 32'h1000, OPM_RD};
    arbTab[1] = '{OPM_READY,   OPM_WR,    2'b10, 32'h2000, OPM_WR};
    arbTab[2] = '{OPM_FLUSHIS, OPM_READY, 2'b01, 32'h1000, OPM_FLUSHIS};
    arbTab[3] = '{OPM_RD,      OPM_WR,    RR ? 2'b01 : 2'b10,
                  RR ? 32'h1000 : 32'h2000, RR ? OPM_RD : OPM_WR};

    idleInputs();

    // Response routing while held in reset (everything idle/non-granted).
    for (int k = 0; k < 4; k++) begin
      reset = 1'b0;
      icMemOpm = rstTab[k].ic; dcMemOpm = rstTab[k].dc; memOK = rstTab[k].mok;
      #1;
      chk("tabRst.icMemOK", icMemOK, rstTab[k].eIc);
      chk("tabRst.dcMemOK", dcMemOK, rstTab[k].eDc);
      chk("tabRst.memOpm", memOpm, OPM_READY);
      chk("tabRst.arbGrant", arbGrant, 2'b00);
    end

    // First grant straight out of reset.
    for (int k = 0; k < 4; k++) begin
      reset = 1'b0;
      idleInputs();
      #1;
      icMemAddr = 32'h1000; dcMemAddr = 32'h2000;
      icMemOpm = arbTab[k].ic; dcMemOpm = arbTab[k].dc;
      #1;
      reset = 1'b1;
      tick();
      chk("tabArb.arbGrant", arbGrant, arbTab[k].eGnt);
      chk("tabArb.memAddr", memAddr, arbTab[k].eAddr);
      chk("tabArb.memOpm", memOpm, arbTab[k].eOpm);
    end

    // Idle after reset release.
    rstPulse();
    #1;
    chk("idle.memOpm", memOpm, OPM_READY);
    chk("idle.icMemOK", icMemOK, OK_READY);
    chk("idle.dcMemOK", dcMemOK, OK_READY);
    chk("idle.arbGrant", arbGrant, 2'b00);
    chk("idle.memAddr", memAddr, 32'd0);
    chk("idle.memDataOut", memDataOut, 128'd0);

    // I-only tile read, three HOLD cycles then OK.
    icMemOpm = OPM_RD; icMemAddr = 32'h00001230;
    #1;
    chk("iRead.freshHold", icMemOK, OK_HOLD);
    tick();
    chk("iRead.memOpm", memOpm, OPM_RD);
    chk("iRead.memAddr", memAddr, 32'h00001230);
    chk("iRead.arbGrant", arbGrant, 2'b01);
    for (int k = 0; k < 3; k++) begin
      memOK = OK_HOLD;
      #1;
      chk("iRead.hold", icMemOK, OK_HOLD);
      chk("iRead.dcIdle", dcMemOK, OK_READY);
      tick();
    end
    memOK = OK_OK; memDataIn = {4{32'hA5A5A5A5}};
    #1;
    chk("iRead.ok", icMemOK, OK_OK);
    chk("iRead.data", icMemData, {4{32'hA5A5A5A5}});
    chk("iRead.dcIdle2", dcMemOK, OK_READY);
    tick();
    chk("iRead.memOpmDone", memOpm, OPM_READY);
    chk("iRead.grantHeld", arbGrant, 2'b01);
    icMemOpm = OPM_READY; memOK = OK_READY;
    tick();
    chk("iRead.released", arbGrant, 2'b00);

    // Simultaneous requests.
    firstGnt   = RR ? 2'b01 : 2'b10;
    secondGnt  = RR ? 2'b10 : 2'b01;
    firstAddr  = RR ? 32'h100 : 32'h200;
    secondAddr = RR ? 32'h200 : 32'h100;
    rstPulse();
    icMemOpm = OPM_RD; icMemAddr = 32'h100;
    dcMemOpm = OPM_RD; dcMemAddr = 32'h200;
    tick();
    chk("both.firstGnt", arbGrant, firstGnt);
    chk("both.firstAddr", memAddr, firstAddr);
    chk("both.otherHold", RR ? dcMemOK : icMemOK, OK_HOLD);
    memOK = OK_OK;
    #1;
    chk("both.firstOK", RR ? icMemOK : dcMemOK, OK_OK);
    tick();
    memOK = OK_READY;
    if (RR) icMemOpm = OPM_READY; else dcMemOpm = OPM_READY;
    tick();
    chk("both.deadCycle", arbGrant, 2'b00);
    chk("both.stillHold", RR ? dcMemOK : icMemOK, OK_HOLD);
    tick();
    chk("both.secondGnt", arbGrant, secondGnt);
    chk("both.secondAddr", memAddr, secondAddr);

    // Watchdog on a D-side write with the downstream stuck at HOLD.
    rstPulse();
    dcMemOpm = OPM_WR; dcMemAddr = 32'h300; dcMemDataOut = {4{32'hDEADBEEF}};
    memOK = OK_HOLD;
    tick();
    chk("wd.memDataOut", memDataOut, {4{32'hDEADBEEF}});
    for (int k = 1; k <= TO; k++) begin
      chk("wd.waiting", dcMemOK, OK_HOLD);
      chk("wd.memOpm", memOpm, OPM_WR);
      tick();
    end
    chk("wd.fault", dcMemOK, OK_FAULT);
    chk("wd.memOpmReady", memOpm, OPM_READY);
    tick();
    chk("wd.waitRequester", arbGrant, 2'b10);
    dcMemOpm = OPM_READY;
    tick();
    chk("wd.release", arbGrant, 2'b00);

    // Downstream FAULT passed through on D, then an I request is served.
    rstPulse();
    dcMemOpm = OPM_RD; dcMemAddr = 32'h400;
    tick();
    memOK = OK_FAULT;
    #1;
    chk("dsFault.dc", dcMemOK, OK_FAULT);
    chk("dsFault.ic", icMemOK, OK_READY);
    tick();
    dcMemOpm = OPM_READY; memOK = OK_READY;
    tick();
    icMemOpm = OPM_RD; icMemAddr = 32'h440;
    tick();
    chk("dsFault.next", arbGrant, 2'b01);
    memOK = OK_OK;
    #1;
    chk("dsFault.nextOK", icMemOK, OK_OK);

    // Reset pulse in the middle of a transaction.
    rstPulse();
    icMemOpm = OPM_RD; icMemAddr = 32'h500;
    tick();
    chk("midRst.granted", arbGrant, 2'b01);
    memOK = OK_HOLD;
    #2;
    reset = 1'b0;
    #1;
    chk("midRst.memOpm", memOpm, OPM_READY);
    chk("midRst.arbGrant", arbGrant, 2'b00);
    chk("midRst.icHold", icMemOK, OK_HOLD);
    tick();
    reset = 1'b1; memOK = OK_READY;
    tick();
    chk("midRst.regrant", arbGrant, 2'b01);
    chk("midRst.addr", memAddr, 32'h500);

    // Randomized traffic against the transaction-level model.
    rstPulse();
    mOwner = 0; mLast = 2; mReqCnt = 0; mFin = 1'b0; mTo = 1'b0;
    eOpm = OPM_READY; eAddr = 32'd0; eData = 128'd0;
    iSeen = OK_READY; dSeen = OK_READY; dsBusy = 1'b0; dsDone = 1'b0;
    dsLat = 0; dsHold = 0; dsResp = OK_OK;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Requesters: hold until answered, occasionally abandon or re-address.
      if (icMemOpm != OPM_READY) begin
        if (iSeen == OK_OK || iSeen == OK_FAULT || $urandom_range(0, 49) == 0)
          icMemOpm = OPM_READY;
        else if ($urandom_range(0, 15) == 0)
          icMemAddr = $urandom;
      end else if (iSeen == OK_READY && $urandom_range(0, 3) == 0) begin
        icMemOpm = rndOpm(); icMemAddr = $urandom;
      end
      if (dcMemOpm != OPM_READY) begin
        if (dSeen == OK_OK || dSeen == OK_FAULT || $urandom_range(0, 49) == 0)
          dcMemOpm = OPM_READY;
        else if ($urandom_range(0, 15) == 0) begin
          dcMemAddr = $urandom; dcMemDataOut = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if (dSeen == OK_READY && $urandom_range(0, 3) == 0) begin
        dcMemOpm = rndOpm(); dcMemAddr = $urandom;
        dcMemDataOut = {$urandom, $urandom, $urandom, $urandom};
      end

      // Downstream: random latency (sometimes past the watchdog), OK or
      // FAULT, answer held a few cycles after the request drops.
      if (!dsBusy && memOpm != OPM_READY) begin
        dsBusy = 1'b1; dsDone = 1'b0; dsLat = $urandom_range(0, 11);
      end
      if (!dsBusy) memOK = OK_READY;
      else if (!dsDone) begin
        if (memOpm == OPM_READY) begin dsBusy = 1'b0; memOK = OK_READY; end
        else if (dsLat == 0) begin
          dsDone = 1'b1; dsHold = $urandom_range(0, 2);
          dsResp = ($urandom_range(0, 7) == 0) ? OK_FAULT : OK_OK;
          memOK = dsResp;
        end else begin dsLat--; memOK = OK_HOLD; end
      end else if (memOpm == OPM_READY) begin
        if (dsHold == 0) begin dsBusy = 1'b0; memOK = OK_READY; end
        else begin dsHold--; memOK = dsResp; end
      end else memOK = dsResp;
      memDataIn = {$urandom, $urandom, $urandom, $urandom};
      #1;

      eGnt  = (mOwner == 1) ? 2'b01 : (mOwner == 2) ? 2'b10 : 2'b00;
      eIcOK = (mOwner == 1) ? (mTo ? OK_FAULT : memOK)
                            : ((icMemOpm != OPM_READY) ? OK_HOLD : OK_READY);
      eDcOK = (mOwner == 2) ? (mTo ? OK_FAULT : memOK)
                            : ((dcMemOpm != OPM_READY) ? OK_HOLD : OK_READY);
      chk("rnd.memOpm", memOpm, eOpm);
      chk("rnd.arbGrant", arbGrant, eGnt);
      chk("rnd.icMemOK", icMemOK, eIcOK);
      chk("rnd.dcMemOK", dcMemOK, eDcOK);
      if (mOwner != 0) chk("rnd.memAddr", memAddr, eAddr);
      if (mOwner == 2) chk("rnd.memDataOut", memDataOut, eData);
      if (mOwner == 1) chk("rnd.icMemData", icMemData, memDataIn);
      if (mOwner == 2) chk("rnd.dcMemData", dcMemData, memDataIn);
      iSeen = icMemOK; dSeen = dcMemOK;

      // Model advance across the coming edge.
      ownOpm = (mOwner == 2) ? dcMemOpm : icMemOpm;
      if (mOwner == 0) begin
        if (icMemOpm != OPM_READY || dcMemOpm != OPM_READY) begin
          if (icMemOpm != OPM_READY && dcMemOpm != OPM_READY)
            winner = RR ? ((mLast == 2) ? 1 : 2) : 2;
          else
            winner = (icMemOpm != OPM_READY) ? 1 : 2;
          mOwner = winner; mFin = 1'b0; mTo = 1'b0; mReqCnt = 0;
          eOpm  = (winner == 1) ? icMemOpm  : dcMemOpm;
          eAddr = (winner == 1) ? icMemAddr : dcMemAddr;
          eData = (winner == 1) ? 128'd0    : dcMemDataOut;
        end
      end else if (!mFin) begin
        if (ownOpm != OPM_READY) begin
          eOpm  = ownOpm;
          eAddr = (mOwner == 1) ? icMemAddr : dcMemAddr;
          eData = (mOwner == 1) ? 128'd0    : dcMemDataOut;
        end
        if (memOK == OK_OK || memOK == OK_FAULT) begin
          mFin = 1'b1; eOpm = OPM_READY;
        end else begin
          mReqCnt++;
          if (mReqCnt == TO) begin mFin = 1'b1; mTo = 1'b1; eOpm = OPM_READY; end
        end
      end else if (ownOpm == OPM_READY && (memOK == OK_READY || mTo)) begin
        mLast = mOwner; mOwner = 0; mTo = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
